// File: rtl/jtdd_mcu_com.sv
// jtdd_mcu_com: responder side of the main CPU <-> MCU link.
// Holds the shared RAM and time-slices it between main CPU and MCU.
// Also provides the MCU NMI latch, the main IRQ pulse and the halt / bus-available handshake.
module jtdd_mcu_com #(
  parameter int AW       = 9,
  parameter int IRQ_HOLD = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          main_cen,
  input  logic          mcu_cen,
  // main CPU window
  input  logic          com_cs,
  input  logic [AW-1:0] main_addr,
  input  logic          main_rnw,
  input  logic [7:0]    main_dout,
  output logic [7:0]    mcu_ram,
  input  logic          mcu_nmi_set,
  input  logic          mcu_halt,
  input  logic          mcu_rstb,
  output logic          mcu_irqmain,
  output logic          mcu_ban,
  // MCU side
  input  logic          mcu_ram_cs,
  input  logic [AW-1:0] mcu_addr,
  input  logic          mcu_wr,
  input  logic [7:0]    mcu_dout,
  output logic [7:0]    mcu_din,
  output logic          mcu_nmi,
  input  logic          mcu_nmi_ack,
  input  logic          mcu_irq_req,
  output logic          mcu_haltn,
  input  logic          mcu_ba,
  // halt FSM state for observation: 0 RUN, 1 HREQ, 2 HALTED, 3 REL
  output logic [1:0]    st_dbg
);

  typedef enum logic [1:0] {RUN = 2'd0, HREQ = 2'd1, HALTED = 2'd2, REL = 2'd3} st_t;

  localparam int CW = $clog2(IRQ_HOLD + 1);

  st_t           r_st;
  logic          r_slot;
  logic [7:0]    r_mem [0:(1<<AW)-1];
  logic          r_mpend, r_upend;
  logic [AW-1:0] r_maddr, r_uaddr;
  logic [7:0]    r_mdata, r_udata;
  logic          r_nmi_set_l, r_irq_req_l;
  logic [CW-1:0] r_irq_cnt;

  logic          w_main_slot, w_mcu_slot;
  logic          w_main_we, w_mcu_we, w_main_re, w_mcu_re;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_wdata;
  logic          w_nmi_rise, w_irq_rise;

  // Slot ownership: HALTED hands every slot to main, otherwise alternate.
  assign w_main_slot = r_slot | (r_st == HALTED);
  assign w_mcu_slot  = ~w_main_slot;
  // A pending write takes the slot; a read only happens in a slot with nothing to commit.
  assign w_main_we   = w_main_slot & r_mpend;
  assign w_mcu_we    = w_mcu_slot & r_upend;
  assign w_main_re   = w_main_slot & ~r_mpend & com_cs & main_rnw;
  assign w_mcu_re    = w_mcu_slot & ~r_upend & mcu_ram_cs & ~mcu_wr;
  assign w_we        = w_main_we | w_mcu_we;
  assign w_addr      = w_main_slot ? (r_mpend ? r_maddr : main_addr)
                                   : (r_upend ? r_uaddr : mcu_addr);
  assign w_wdata     = w_main_slot ? r_mdata : r_udata;
  assign w_nmi_rise  = mcu_nmi_set & ~r_nmi_set_l;
  assign w_irq_rise  = mcu_irq_req & ~r_irq_req_l;
  assign st_dbg      = r_st;

  // Free-running slot toggle.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_slot <= 1'b0;
    else     r_slot <= ~r_slot;

  // Shared RAM array; contents survive both resets.
  always_ff @(posedge clk)
    if (w_we) r_mem[w_addr] <= w_wdata;

  // Registered read data, held between the owner's slots.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mcu_ram <= 8'hFF;
      mcu_din <= 8'hFF;
    end else begin
      if (w_main_re) mcu_ram <= r_mem[w_addr];
      if (w_mcu_re)  mcu_din <= r_mem[w_addr];
    end

  // Main pending write: captured on main_cen, retired in the next main slot.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_mpend <= 1'b0;
      r_maddr <= '0;
      r_mdata <= 8'h00;
    end else if (main_cen & com_cs & ~main_rnw) begin
      r_mpend <= 1'b1;
      r_maddr <= main_addr;
      r_mdata <= main_dout;
    end else if (w_main_we) begin
      r_mpend <= 1'b0;
    end

  // MCU pending write: captured on mcu_cen, retired in the next MCU slot.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_upend <= 1'b0;
      r_uaddr <= '0;
      r_udata <= 8'h00;
    end else if (!mcu_rstb) begin
      r_upend <= 1'b0;
    end else if (mcu_cen & mcu_ram_cs & mcu_wr) begin
      r_upend <= 1'b1;
      r_uaddr <= mcu_addr;
      r_udata <= mcu_dout;
    end else if (w_mcu_we) begin
      r_upend <= 1'b0;
    end

  // NMI latch: set on a rising edge of the set strobe, which beats a same-cycle ack.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_nmi_set_l <= 1'b0;
      mcu_nmi     <= 1'b0;
    end else begin
      r_nmi_set_l <= mcu_nmi_set;
      if (!mcu_rstb)                  mcu_nmi <= 1'b0;
      else if (w_nmi_rise)            mcu_nmi <= 1'b1;
      else if (mcu_nmi_ack & mcu_cen) mcu_nmi <= 1'b0;
    end

  // Main IRQ pulse: held for IRQ_HOLD main_cen strobes, a fresh edge reloads the count.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_irq_req_l <= 1'b0;
      mcu_irqmain <= 1'b0;
      r_irq_cnt   <= '0;
    end else begin
      r_irq_req_l <= mcu_irq_req;
      if (!mcu_rstb) begin
        mcu_irqmain <= 1'b0;
        r_irq_cnt   <= '0;
      end else if (w_irq_rise) begin
        mcu_irqmain <= 1'b1;
        r_irq_cnt   <= CW'(IRQ_HOLD);
      end else if (mcu_irqmain & main_cen) begin
        if (r_irq_cnt <= CW'(1)) begin
          mcu_irqmain <= 1'b0;
          r_irq_cnt   <= '0;
        end else begin
          r_irq_cnt <= r_irq_cnt - CW'(1);
        end
      end
    end

  // Halt handshake FSM with registered haltn / ban.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_st      <= RUN;
      mcu_haltn <= 1'b1;
      mcu_ban   <= 1'b0;
    end else if (!mcu_rstb) begin
      r_st      <= RUN;
      mcu_haltn <= 1'b1;
      mcu_ban   <= 1'b0;
    end else begin
      case (r_st)
        RUN: if (mcu_halt) begin
          r_st      <= HREQ;
          mcu_haltn <= 1'b0;
        end
        HREQ: if (!mcu_halt) begin
          r_st      <= RUN;
          mcu_haltn <= 1'b1;
        end else if (mcu_ba) begin
          r_st    <= HALTED;
          mcu_ban <= 1'b1;
        end
        HALTED: if (!mcu_halt) begin
          r_st      <= REL;
          mcu_haltn <= 1'b1;
          mcu_ban   <= 1'b0;
        end
        REL: if (!mcu_ba) r_st <= RUN;
        default: begin
          r_st      <= RUN;
          mcu_haltn <= 1'b1;
          mcu_ban   <= 1'b0;
        end
      endcase
    end

endmodule

// File: doc/jtdd_mcu_com.md
# jtdd_mcu_com

Responder side of the main-CPU ↔ MCU link in the Double Dragon core. It holds the 512-byte shared RAM and arbitrates it between the main CPU window (`com_cs`) and the HD63701 MCU. It also turns the main CPU's NMI-set writes into an MCU NMI latch and the MCU's interrupt requests into a main-CPU IRQ edge. It runs the halt / bus-available handshake driven by the main CPU's misc register.

## Interface
Parameters:
- AW, 9, shared RAM address width (2^AW bytes)
- IRQ_HOLD, 2, number of `main_cen` strobes `mcu_irqmain` stays high

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- main_cen  in  1  main CPU clock enable (3 MHz strobe)
- mcu_cen  in  1  MCU clock enable
- com_cs  in  1  main CPU selects shared RAM window
- main_addr  in  AW  main CPU address, cpu_AB[AW-1:0]
- main_rnw  in  1  main CPU read (1) / write (0)
- main_dout  in  8  main CPU write data
- mcu_ram  out  8  read data returned to main CPU
- mcu_nmi_set  in  1  main write strobe to NMI-set location, registered, may last several clk
- mcu_halt  in  1  halt request level from main misc register
- mcu_rstb  in  1  MCU run enable from main; 0 holds MCU link in reset
- mcu_irqmain  out  1  IRQ edge toward main CPU interrupt flip-flop
- mcu_ban  out  1  1 = MCU halted, bus handed to main
- mcu_ram_cs  in  1  MCU selects shared RAM
- mcu_addr  in  AW  MCU address
- mcu_wr  in  1  MCU write strobe, qualified by mcu_cen
- mcu_dout  in  8  MCU write data
- mcu_din  out  8  read data to MCU
- mcu_nmi  out  1  NMI level to MCU
- mcu_nmi_ack  in  1  MCU clears NMI, one mcu_cen strobe
- mcu_irq_req  in  1  MCU port bit requesting main IRQ, level
- mcu_haltn  out  1  halt line to MCU, active-low
- mcu_ba  in  1  MCU bus-available acknowledge

## Operation
- RAM:
  - One single-port 2^AW×8 block.
  - A free-running 1-bit slot toggle `slot` runs on clk: slot 0 serves the MCU, slot 1 serves main.
  - In state HALTED every slot serves main.
  - A write happens only in its owner's slot:
    - main writes when `com_cs & ~main_rnw`
    - MCU writes when `mcu_ram_cs & mcu_wr`
  - A write request is captured in a per-side pending register on its cen. It is committed in that side's next slot, then cleared.
  - Reads return data registered at the owner's slot. `mcu_ram` and `mcu_din` each hold their last value between slots.
- NMI latch:
  - A rising edge of `mcu_nmi_set` (edge detected on clk) sets `mcu_nmi`.
  - `mcu_nmi_ack` with `mcu_cen` clears it.
  - Set and clear in the same cycle: set wins.
- Main IRQ:
  - A rising edge of `mcu_irq_req` sets `mcu_irqmain`.
  - A counter clears it after IRQ_HOLD `main_cen` strobes.
  - A new edge while high reloads the counter; the output stays high and makes no extra edge.
- Halt FSM, states RUN, HREQ, HALTED, REL:
  - RUN: `haltn`=1, `ban`=0. Moves to HREQ when `mcu_halt`=1.
  - HREQ: `haltn`=0. Moves to HALTED when `mcu_ba`=1. If `mcu_halt` drops first, returns to RUN.
  - HALTED: `haltn`=0, `ban`=1. Moves to REL when `mcu_halt`=0.
  - REL: `haltn`=1, `ban`=0. Moves to RUN when `mcu_ba`=0.
- `mcu_rstb`=0 acts as a synchronous reset on the link:
  - forces RUN
  - clears the NMI latch, `mcu_irqmain`, the IRQ counter and MCU pending writes
  - leaves RAM contents and main pending writes untouched.

## Timing
- Reset values:
  - `mcu_ram`=0xFF, `mcu_din`=0xFF
  - `mcu_nmi`=0, `mcu_irqmain`=0, `mcu_ban`=0, `mcu_haltn`=1
  - state=RUN, `slot`=0, pending writes cleared, edge detectors cleared to 0. RAM is not cleared.
- Worst-case write latency: 2 clk from cen to RAM commit. Read latency: ≤2 clk.
  - With `cen12`=clk/4 and `main_cen`=cen12/4, data is stable long before the next CPU strobe.
- Same-address collision: main and MCU write the same address in adjacent slots → the later slot wins, no merge.
- NMI: `mcu_nmi` rises 1 clk after the `mcu_nmi_set` rising edge and falls 1 clk after the qualified ack.
- IRQ: `mcu_irqmain` rises 1 clk after the `mcu_irq_req` edge.
- Halt outputs are registered: `mcu_haltn` falls 1 clk after `mcu_halt` rises; `mcu_ban` rises 1 clk after `mcu_ba` is seen in HREQ.
- Asynchronous `rst` mid-transfer drops the pending write; the RAM location keeps its old value.

## Test plan
- Main writes 0x5A to 0x1F3, then MCU reads 0x1F3 → `mcu_din`=0x5A within 2 clk of the MCU read strobe. Repeat with MCU writing 0xA5 → `mcu_ram`=0xA5.
- Back-to-back writes of 0x11 (main) and 0x22 (MCU) to 0x000, MCU slot after main slot → location reads 0x22.
- `mcu_nmi_set` pulse of 3 clk → `mcu_nmi`=1 once. Ack and a new set edge in the same clk → `mcu_nmi` stays 1. Ack alone → 0.
- `mcu_irq_req` 0→1 → `mcu_irqmain` high for exactly IRQ_HOLD=2 `main_cen` strobes, then 0. Holding the req high → no second pulse.
- `mcu_halt`=1, `mcu_ba`=1 after 5 clk → `mcu_ban`=1. During HALTED, 4 consecutive main writes all commit. `mcu_halt`=0 → `mcu_ban`=0, `mcu_haltn`=1, RUN after `mcu_ba`=0.
- During HALTED with `mcu_nmi`=1, drive `mcu_rstb`=0 → state RUN, `mcu_nmi`=0, `mcu_ban`=0. A previously written RAM byte is still readable. Async `rst` → all outputs at their reset values.
